ikaopll_dac_sampler: RTL

Receive-side block for the impulse DAC interface. It consumes the time-multiplexed sign+magnitude impulse stream (melody and rhythm, no-fluctuation form) and decodes it back into one signed PCM sample per 18-slot frame. Each frame yields separate melody and rhythm sums and their mix. Samples are buffered in a 2-entry FIFO with a valid/ready handshake, so a host-side audio path (I2S/resampler) can drain them.

---
 rtl/ikaopll_pkg.sv | 20 ++
 rtl/ikaopll_sample_fifo.sv | 54 +++++
 rtl/ikaopll_dac_sampler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ikaopll_pkg.sv
// rtl/ikaopll_pkg.sv - shared constants, sync state and impulse decode for the DAC sampler
package ikaopll_pkg;

    localparam int SLOTS_PER_FRAME = 18;
    localparam int ACC_WIDTH       = 14;
    localparam int SLOT_WIDTH      = 5;

    typedef enum logic {
        UNSYNC = 1'b0,
        RUN    = 1'b1
    } sync_state_t;

    // Sign+magnitude impulse to two's complement; a zero magnitude stays zero for either sign.
    function automatic logic signed [ACC_WIDTH-1:0] decode_imp(input logic sign, input logic [8:0] mag);
        logic signed [ACC_WIDTH-1:0] m;
        m = $signed({{(ACC_WIDTH-9){1'b0}}, mag});
        return sign ? -m : m;
    endfunction

endpackage

// File: rtl/ikaopll_sample_fifo.sv
// rtl/ikaopll_sample_fifo.sv - synchronous sample FIFO with push/pop/full/empty
module ikaopll_sample_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic             emuclk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge emuclk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge emuclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ikaopll_dac_sampler.sv
// rtl/ikaopll_dac_sampler.sv - decodes the impulse DAC stream into per-frame melody/rhythm/mix samples
module ikaopll_dac_sampler
    import ikaopll_pkg::*;
#(
    parameter int OUT_WIDTH      = 16,
    parameter int RHY_GAIN_SHIFT = 1,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    input  logic                 i_phi1_NCEN_n,
    input  logic                 i_CYCLE_00,
    input  logic                 i_IMP_NOFLUC_SIGN,
    input  logic [8:0]           i_IMP_NOFLUC_MAG_MO,
    input  logic [8:0]           i_IMP_NOFLUC_MAG_RO,
    output logic                 o_SAMPLE_VALID,
    input  logic                 i_SAMPLE_READY,
    output logic [OUT_WIDTH-1:0] o_FM,
    output logic [OUT_WIDTH-1:0] o_RHY,
    output logic [OUT_WIDTH-1:0] o_MIX,
    output logic                 o_SYNC_ERR,
    output logic                 o_OVERRUN
);

    localparam int SW = (OUT_WIDTH > ACC_WIDTH + 1) ? OUT_WIDTH : ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [SLOT_WIDTH-1:0] SLOT_FULL = SLOT_WIDTH'(SLOTS_PER_FRAME);
    localparam int DW = 3 * OUT_WIDTH;

    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] x);
        logic signed [SW-1:0] xe;
        xe = SW'(x);
        if (xe > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (xe < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return xe[OUT_WIDTH-1:0];
    endfunction

    sync_state_t                 state, state_nxt;
    logic [SLOT_WIDTH-1:0]       slot, slot_nxt;
    logic signed [ACC_WIDTH-1:0] fm_acc, fm_nxt;
    logic signed [ACC_WIDTH-1:0] rhy_acc, rhy_nxt;
    logic signed [ACC_WIDTH-1:0] mo;
    logic signed [ACC_WIDTH-1:0] ro;
    logic signed [ACC_WIDTH:0]   mix_sum;
    logic                        step;
    logic                        push_frame;
    logic                        sync_err_set;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_fire;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] fifo_rdata;
    logic [DW-1:0] last_q;
    logic          sync_err_q;
    logic          overrun_q;

    assign step    = !i_phi1_NCEN_n;
    assign mo      = decode_imp(i_IMP_NOFLUC_SIGN, i_IMP_NOFLUC_MAG_MO);
    assign ro      = decode_imp(i_IMP_NOFLUC_SIGN, i_IMP_NOFLUC_MAG_RO) <<< RHY_GAIN_SHIFT;
    assign mix_sum = {fm_acc[ACC_WIDTH-1], fm_acc} + {rhy_acc[ACC_WIDTH-1], rhy_acc};

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state   <= UNSYNC;
            slot    <= '0;
            fm_acc  <= '0;
            rhy_acc <= '0;
        end else begin
            state   <= state_nxt;
            slot    <= slot_nxt;
            fm_acc  <= fm_nxt;
            rhy_acc <= rhy_nxt;
        end
    end

    // Any frame-start step seeds a fresh frame with its own slot input.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        fm_nxt    = fm_acc;
        rhy_nxt   = rhy_acc;
        if (step) begin
            if (i_CYCLE_00) begin
                state_nxt = RUN;
                slot_nxt  = SLOT_WIDTH'(1);
                fm_nxt    = mo;
                rhy_nxt   = ro;
            end else if (state == RUN) begin
                if (slot < SLOT_FULL) begin
                    slot_nxt = slot + 1'b1;
                    fm_nxt   = fm_acc + mo;
                    rhy_nxt  = rhy_acc + ro;
                end else begin
                    state_nxt = UNSYNC;
                    slot_nxt  = '0;
                    fm_nxt    = '0;
                    rhy_nxt   = '0;
                end
            end
        end
    end

    always_comb begin
        push_frame   = 1'b0;
        sync_err_set = 1'b0;
        if (step && state == RUN) begin
            push_frame   = i_CYCLE_00 && (slot == SLOT_FULL);
            sync_err_set = i_CYCLE_00 ^ (slot == SLOT_FULL);
        end
    end

    assign fifo_wdata = {sat({fm_acc[ACC_WIDTH-1], fm_acc}),
                         sat({rhy_acc[ACC_WIDTH-1], rhy_acc}),
                         sat(mix_sum)};
    assign pop_fire   = i_SAMPLE_READY && !fifo_empty;

    ikaopll_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .emuclk (i_EMUCLK),
        .rst    (i_RST),
        .push   (push_frame),
        .pop    (pop_fire),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            last_q     <= '0;
            sync_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_err_q <= sync_err_set;
            if (pop_fire) begin
                last_q <= fifo_rdata;
            end
            if (push_frame && fifo_full && !pop_fire) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // With the FIFO empty the outputs keep showing the most recently consumed sample.
    assign o_SAMPLE_VALID = !fifo_empty;
    assign o_FM           = fifo_empty ? last_q[DW-1 -: OUT_WIDTH]          : fifo_rdata[DW-1 -: OUT_WIDTH];
    assign o_RHY          = fifo_empty ? last_q[2*OUT_WIDTH-1 -: OUT_WIDTH] : fifo_rdata[2*OUT_WIDTH-1 -: OUT_WIDTH];
    assign o_MIX          = fifo_empty ? last_q[OUT_WIDTH-1:0]              : fifo_rdata[OUT_WIDTH-1:0];
    assign o_SYNC_ERR     = sync_err_q;
    assign o_OVERRUN      = overrun_q;

endmodule
